dec_onehot_strobe: RTL and testbench
====================================

// Module: dec_onehot_strobe
// PURPOSE
//  Parametrised, registered one-hot decoder with a valid/ready handshake.
//  Converts a binary select into NUM_OUT enables, held as a level or stretched
//  as a timed strobe. Drives register/channel selects in the UART datapath.
//  Successor to the combinational 8-to-256 decoder; adds registered outputs,
//  pulse mode, range checking and abort.
// PARAMETERS
//  SEL_W    8    width of binary select input
//  NUM_OUT  256  number of one-hot outputs; 1 <= NUM_OUT <= 2**SEL_W
//  STRETCH  4    cycles out_o is held in pulse mode; >= 1
//  CNT_W    8    stretch counter width; 2**CNT_W > STRETCH
// PORTS
//  clk      in   1        system clock, all state on rising edge
//  reset_n  in   1        asynchronous, active-low reset
//  sel_i    in   SEL_W    binary index to decode
//  valid_i  in   1        request present on sel_i/mode_i
//  mode_i   in   1        0 = level (hold), 1 = pulse (STRETCH cycles)
//  clear_i  in   1        synchronous abort; forces outputs to zero
//  ready_o  out  1        block can accept a request this cycle
//  out_o    out  NUM_OUT  registered one-hot select, all-zero when idle
//  busy_o   out  1        pulse stretch in progress
//  err_o    out  1        one-cycle flag: accepted sel_i >= NUM_OUT
// BEHAVIOUR
//  - Reset (reset_n=0, async): out_o=0, busy_o=0, err_o=0, state IDLE.
//    ready_o=1 as soon as reset_n=1.
//  - States: IDLE (out_o=0), HOLD (level held), STRETCH (pulse active).
//  - ready_o = (state != STRETCH). Decoded from the state register only, never
//    from inputs.
//  - Accept = valid_i & ready_o at a rising edge. sel_i and mode_i are sampled
//    only at accept.
//  - Latency: out_o reflects the accepted sel_i from the edge of acceptance,
//    visible in the next cycle. No combinational path from sel_i to out_o.
//  - In-range accept, mode 0: out_o <= 1<<sel_i; go to HOLD. HOLD persists until
//    the next accept (replaces the bit in one edge, no zero gap) or clear_i.
//  - In-range accept, mode 1: out_o <= 1<<sel_i; cnt <= STRETCH-1; busy_o <= 1;
//    go to STRETCH. Each cycle cnt decrements. At the edge where cnt==0:
//    out_o <= 0, busy_o <= 0, go to IDLE. out_o is high exactly STRETCH cycles.
//  - Out-of-range accept (sel_i >= NUM_OUT), either mode: out_o <= 0,
//    err_o <= 1 for one cycle, go to IDLE. Never wraps or aliases.
//  - err_o is 0 on every cycle not immediately following an out-of-range accept.
//  - clear_i has priority over accept and countdown: out_o <= 0, busy_o <= 0,
//    cnt <= 0, go to IDLE. Any accept in the same cycle is dropped and err_o is
//    not raised.
//  - Requests with valid_i=1 during STRETCH are not accepted. The requester
//    holds valid_i until ready_o is seen.
//  - At most one out_o bit is ever high.
//  - reset_n low mid-stretch clears outputs immediately (async).
// TESTING
//  1. Reset, then level sel=8'h05 -> out_o[5]=1 next cycle, ready_o=1, stays
//     set 20 cycles.
//  2. In HOLD[5], accept level sel=8'hFF -> out_o changes to bit 255 in one
//     edge, no all-zero cycle.
//  3. Pulse sel=8'h10, STRETCH=4 -> out_o[16]=1 for exactly 4 cycles,
//     ready_o=0/busy_o=1 for those 4, then out_o=0.
//  4. valid_i held during stretch with sel=8'h20 -> accepted the cycle ready_o
//     returns; out_o[32] follows with no overlap.
//  5. NUM_OUT=200, sel=8'd200 -> out_o=0, err_o=1 one cycle; sel=8'd199 ->
//     out_o[199]=1, err_o=0.
//  6. clear_i with valid_i mid-stretch, then reset_n pulsed low mid-stretch ->
//     both drop out_o to 0, IDLE, ready_o=1, no err_o.

Source files
------------

// File: rtl/dec_onehot_strobe_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_onehot_strobe_if
// Purpose  : Request/response bundle for the registered one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface dec_onehot_strobe_if #(
    parameter int SEL_W   = 8,
    parameter int NUM_OUT = 256
);
    logic [SEL_W-1:0]   sel_i;
    logic               valid_i;
    logic               mode_i;
    logic               clear_i;
    logic               ready_o;
    logic [NUM_OUT-1:0] out_o;
    logic               busy_o;
    logic               err_o;

    modport master (
        output sel_i, valid_i, mode_i, clear_i,
        input  ready_o, out_o, busy_o, err_o
    );

    modport slave (
        input  sel_i, valid_i, mode_i, clear_i,
        output ready_o, out_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/dec_onehot_strobe.sv
`default_nettype none
// ============================================================================
// Module   : dec_onehot_strobe
// Purpose  : Registered one-hot decoder, level-hold or timed-strobe output.
// Revision : 1.0 - initial release
// ============================================================================
module dec_onehot_strobe #(
    parameter int SEL_W   = 8,
    parameter int NUM_OUT = 256,
    parameter int STRETCH = 4,
    parameter int CNT_W   = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    dec_onehot_strobe_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_STRETCH = 2'd2
    } state_t;

    localparam logic [SEL_W:0]     c_num_out  = (SEL_W+1)'(NUM_OUT);
    localparam logic [NUM_OUT-1:0] c_one      = NUM_OUT'(1);
    localparam logic [CNT_W-1:0]   c_cnt_load = CNT_W'(STRETCH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_OUT-1:0] r_out;
    logic               r_busy;
    logic               r_err;

    logic               w_ready;
    logic               w_accept;
    logic               w_in_range;
    logic [NUM_OUT-1:0] w_onehot;

    assign w_ready    = (r_state != S_STRETCH);
    assign w_accept   = bus.valid_i & w_ready;
    // Zero-extended compare so an index past NUM_OUT never aliases onto a real bit.
    assign w_in_range = ({1'b0, bus.sel_i} < c_num_out);
    assign w_onehot   = c_one << bus.sel_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.clear_i) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_out   <= '0;
                r_busy  <= 1'b0;
            end else if (w_accept) begin
                if (!w_in_range) begin
                    r_state <= S_IDLE;
                    r_out   <= '0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b1;
                end else if (bus.mode_i) begin
                    r_state <= S_STRETCH;
                    r_cnt   <= c_cnt_load;
                    r_out   <= w_onehot;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= S_HOLD;
                    r_out   <= w_onehot;
                    r_busy  <= 1'b0;
                end
            end else if (r_state == S_STRETCH) begin
                // Count reaching zero marks the last high cycle of the strobe.
                if (r_cnt == '0) begin
                    r_state <= S_IDLE;
                    r_out   <= '0;
                    r_busy  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.out_o   = r_out;
    assign bus.busy_o  = r_busy;
    assign bus.err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dec_onehot_strobe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_onehot_strobe
// Purpose  : Directed-vector scoreboard bench for dec_onehot_strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_onehot_strobe;

    typedef struct {
        int vid;
        int dut;
        int idx;
        bit rdy;
        bit bsy;
        bit err;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   vid;
    exp_t q[$];

    dec_onehot_strobe_if #(.SEL_W(8), .NUM_OUT(256)) ifa ();
    dec_onehot_strobe_if #(.SEL_W(8), .NUM_OUT(200)) ifb ();

    dec_onehot_strobe #(.SEL_W(8), .NUM_OUT(256), .STRETCH(4), .CNT_W(8)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    dec_onehot_strobe #(.SEL_W(8), .NUM_OUT(200), .STRETCH(4), .CNT_W(8)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [255:0] got,
                       input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s vec%0d: got %h want %h", name, id, got, want);
        end
    endtask

    // Drive one cycle of stimulus on the chosen DUT and queue the post-edge response.
    task automatic vec(input int d, input int sel, input bit v, input bit m,
                       input bit c, input bit r, input int idx,
                       input bit rdy, input bit bsy, input bit err);
        exp_t e;
        @(negedge clk);
        reset_n     = !r;
        ifa.sel_i   = 8'(sel);
        ifb.sel_i   = 8'(sel);
        ifa.valid_i = (d == 0) ? v : 1'b0;
        ifb.valid_i = (d == 1) ? v : 1'b0;
        ifa.mode_i  = m;
        ifb.mode_i  = m;
        ifa.clear_i = (d == 0) ? c : 1'b0;
        ifb.clear_i = (d == 1) ? c : 1'b0;
        e.vid = vid; e.dut = d; e.idx = idx; e.rdy = rdy; e.bsy = bsy; e.err = err;
        q.push_back(e);
        vid++;
    endtask

    task automatic idle(input int d, input int n, input int idx,
                        input bit rdy, input bit bsy);
        for (int i = 0; i < n; i++) vec(d, 0, 0, 0, 0, 0, idx, rdy, bsy, 0);
    endtask

    // Monitor: checks every queued expectation just after the edge it describes.
    initial begin
        exp_t          e;
        logic [255:0]  want;
        logic [255:0]  got_out;
        logic          got_rdy, got_bsy, got_err;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                want = '0;
                if (e.idx >= 0) want[e.idx] = 1'b1;
                if (e.dut == 0) begin
                    got_out = ifa.out_o;
                    got_rdy = ifa.ready_o; got_bsy = ifa.busy_o; got_err = ifa.err_o;
                end else begin
                    got_out = {56'b0, ifb.out_o};
                    got_rdy = ifb.ready_o; got_bsy = ifb.busy_o; got_err = ifb.err_o;
                end
                chk("out",   e.vid, got_out,        want);
                chk("ready", e.vid, 256'(got_rdy),  256'(e.rdy));
                chk("busy",  e.vid, 256'(got_bsy),  256'(e.bsy));
                chk("err",   e.vid, 256'(got_err),  256'(e.err));
            end
        end
    end

    initial begin
        int wait_cnt;
        total = 0; bad = 0; vid = 0;
        reset_n = 1'b0;
        ifa.sel_i = '0; ifa.valid_i = 0; ifa.mode_i = 0; ifa.clear_i = 0;
        ifb.sel_i = '0; ifb.valid_i = 0; ifb.mode_i = 0; ifb.clear_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_out",  -1, ifa.out_o,          '0);
        chk("rst_busy", -1, 256'(ifa.busy_o),   '0);
        chk("rst_err",  -1, 256'(ifa.err_o),    '0);

        // Level select 5 held for 20 cycles.
        vec(0, 8'h05, 1, 0, 0, 0, 5, 1, 0, 0);
        idle(0, 20, 5, 1, 0);
        // Replace with bit 255 in a single edge.
        vec(0, 8'hFF, 1, 0, 0, 0, 255, 1, 0, 0);
        idle(0, 2, 255, 1, 0);
        // Pulse 0x10: four high cycles, then idle.
        vec(0, 8'h10, 1, 1, 0, 0, 16, 0, 1, 0);
        idle(0, 3, 16, 0, 1);
        idle(0, 2, -1, 1, 0);
        // Request held through a strobe is taken once ready returns.
        vec(0, 8'h10, 1, 1, 0, 0, 16, 0, 1, 0);
        for (int i = 0; i < 3; i++) vec(0, 8'h20, 1, 0, 0, 0, 16, 0, 1, 0);
        vec(0, 8'h20, 1, 0, 0, 0, -1, 1, 0, 0);
        vec(0, 8'h20, 1, 0, 0, 0, 32, 1, 0, 0);
        idle(0, 2, 32, 1, 0);

        // 200-output instance: range boundary in both modes.
        vec(1, 200, 1, 0, 0, 0, -1, 1, 0, 1);
        idle(1, 1, -1, 1, 0);
        vec(1, 199, 1, 0, 0, 0, 199, 1, 0, 0);
        idle(1, 1, 199, 1, 0);
        vec(1, 250, 1, 1, 0, 0, -1, 1, 0, 1);
        idle(1, 1, -1, 1, 0);
        vec(1, 199, 1, 0, 0, 0, 199, 1, 0, 0);
        vec(1, 220, 1, 0, 1, 0, -1, 1, 0, 0);
        idle(1, 1, -1, 1, 0);

        // Clear with a competing request mid-strobe.
        vec(0, 8'h03, 1, 1, 0, 0, 3, 0, 1, 0);
        vec(0, 8'h07, 1, 0, 1, 0, -1, 1, 0, 0);
        idle(0, 2, -1, 1, 0);
        // Reset mid-strobe must act without waiting for an edge.
        vec(0, 8'h09, 1, 1, 0, 0, 9, 0, 1, 0);
        idle(0, 1, 9, 0, 1);
        vec(0, 0, 0, 0, 0, 1, -1, 1, 0, 0);
        #1;
        chk("async_out",  -2, ifa.out_o,        '0);
        chk("async_busy", -2, 256'(ifa.busy_o), '0);
        idle(0, 2, -1, 1, 0);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
